// File: rtl/t08_seq_pkg.sv
// t08_seq_pkg: shared types and constants for the t08 multi-cycle sequencer.
//   state_t : sequencer state encoding (also exported on the debug state port)
//   err_t   : sticky error code reported on err_o
//   NOP_INSTR : instruction word presented to the control unit after reset
package t08_seq_pkg;

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    FETCH    = 3'd2,
    DECODE   = 3'd3,
    EXEC     = 3'd4,
    MEM      = 3'd5,
    WB       = 3'd6,
    HALT     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FETCH_TO = 2'd1,
    ERR_DATA_TO  = 2'd2,
    ERR_DECODE   = 2'd3
  } err_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // True in the states that own the memory-handler port.
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/t08_cpu_sequencer_timeout.sv
// t08_seq_timeout: watchdog counter for memory waits.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : force count to zero (has priority over en_i)
//   en_i         : count one waiting cycle
//   expired_o    : count has reached MAX-1, i.e. this is the MAX-th waiting cycle
//   cnt_o        : current count, for debug
module t08_seq_timeout #(
  parameter int MAX = 255,
  localparam int W  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic         expired_o,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count starts at 0 on the first waiting cycle, so LAST marks the MAX-th one.
  assign expired_o = (cnt_q == LAST);
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/t08_cpu_sequencer.sv
// t08_cpu_sequencer: FETCH/DECODE/EXEC/MEM/WB sequencer for the t08 core.
//   clk_i, rst_i        : clock, async active-high reset
//   run_i               : allow a new fetch at the instruction boundary
//   mem_req_o/_fetch_o/_we_o, mem_done_i : shared memory-handler port
//   instr_in_i, instr_q_o : fetched word in, latched instruction out
//   dec_*_i, branch_taken_i : decoded strobes from the control unit / ALU
//   rf_we_o, pc_en_o, pc_load_o : one-cycle writeback and PC-update pulses
//   halted_o, err_o, state_o    : sticky halt, error code, debug state
module t08_cpu_sequencer
  import t08_seq_pkg::*;
#(
  parameter int RESET_STALL = 2,    // must be >= 1
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic        mem_req_o,
  output logic        mem_fetch_o,
  output logic        mem_we_o,
  input  logic        mem_done_i,
  input  logic [31:0] instr_in_i,
  output logic [31:0] instr_q_o,
  input  logic        dec_read_i,
  input  logic        dec_write_i,
  input  logic        dec_en_write_i,
  input  logic        dec_jump_i,
  input  logic        dec_branch_i,
  input  logic        dec_illegal_i,
  input  logic        branch_taken_i,
  output logic        rf_we_o,
  output logic        pc_en_o,
  output logic        pc_load_o,
  output logic        halted_o,
  output logic [1:0]  err_o,
  output logic [2:0]  state_o
);

  localparam int SW = (RESET_STALL > 1) ? $clog2(RESET_STALL) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(RESET_STALL - 1);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state_q, state_d;
  err_t          err_q, err_d;
  logic          halted_q, halted_d;
  logic [31:0]   instr_q, instr_d;
  logic [SW-1:0] stall_q, stall_d;

  logic          to_clr, to_en, to_expired;
  logic [TW-1:0] to_cnt;

  t08_seq_timeout #(.MAX(MEM_TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired),
    .cnt_o     (to_cnt)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    halted_d    = halted_q;
    instr_d     = instr_q;
    stall_d     = stall_q;
    // Counter is held at zero outside FETCH/MEM, so every entry starts from 0.
    to_clr      = !is_mem_state(state_q);
    to_en       = 1'b0;
    mem_req_o   = 1'b0;
    mem_fetch_o = 1'b0;
    mem_we_o    = 1'b0;
    rf_we_o     = 1'b0;
    pc_en_o     = 1'b0;
    pc_load_o   = 1'b0;

    case (state_q)
      RST_WAIT: begin
        if (stall_q == STALL_LAST) begin
          stall_d = '0;
          state_d = run_i ? FETCH : IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      IDLE: if (run_i) state_d = FETCH;
      FETCH: begin
        mem_req_o   = 1'b1;
        mem_fetch_o = 1'b1;
        // mem_done in the expiry cycle takes priority over the timeout.
        if (mem_done_i) begin
          instr_d = instr_in_i;
          state_d = DECODE;
        end else if (to_expired) begin
          state_d = HALT;
          err_d   = ERR_FETCH_TO;
        end else begin
          to_en = 1'b1;
        end
      end
      DECODE: begin
        if (dec_illegal_i || (dec_read_i && dec_write_i)) begin
          state_d = HALT;
          err_d   = ERR_DECODE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: state_d = (dec_read_i || dec_write_i) ? MEM : WB;
      MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = dec_write_i;
        if (mem_done_i) begin
          state_d = WB;
        end else if (to_expired) begin
          state_d = HALT;
          err_d   = ERR_DATA_TO;
        end else begin
          to_en = 1'b1;
        end
      end
      WB: begin
        rf_we_o   = dec_en_write_i;
        pc_en_o   = 1'b1;
        pc_load_o = dec_jump_i || (dec_branch_i && branch_taken_i);
        state_d   = run_i ? FETCH : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    if (state_d == HALT) halted_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RST_WAIT;
      err_q    <= ERR_NONE;
      halted_q <= 1'b0;
      instr_q  <= NOP_INSTR;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      instr_q  <= instr_d;
      stall_q  <= stall_d;
    end
  end

  assign instr_q_o = instr_q;
  assign halted_o  = halted_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule
